fc_operand_feeder: RTL and testbench

FC_OPERAND_FEEDER -- requirements
Module: fc_operand_feeder

---
 rtl/fc_pkg.sv | 16 +
 rtl/fc_addr_gen.sv | 69 ++++++
 rtl/fc_operand_feeder.sv | 179 +++++++++++++++++
 tb/tb_fc_operand_feeder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the FC operand feeder: FSM state encoding and the
// RAM read latency that the valid/bias alignment pipeline is built around.
package fc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } fc_state_e;

  localparam int unsigned RAM_RD_LATENCY = 1;

endpackage

// File: rtl/fc_addr_gen.sv
// Node / output-neuron / weight address counters for the FC operand feeder.
// The weight address is a running counter, so row-major M x N needs no multiplier.
module fc_addr_gen
  import fc_pkg::*;
#(
  parameter int CNT_WIDTH   = 10,
  parameter int WADDR_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clr_i,
  input  logic                   fetch_i,
  input  logic                   adv_i,
  input  logic [CNT_WIDTH-1:0]   num_node_i,
  output logic [CNT_WIDTH-1:0]   node_idx_o,
  output logic [CNT_WIDTH-1:0]   out_idx_o,
  output logic [WADDR_WIDTH-1:0] wegt_addr_o,
  output logic                   last_node_o
);

  logic [CNT_WIDTH-1:0]   node_q, node_d;
  logic [CNT_WIDTH-1:0]   out_q, out_d;
  logic [WADDR_WIDTH-1:0] wegt_q, wegt_d;

  assign last_node_o = (node_q == (num_node_i - CNT_WIDTH'(1)));

  // Next-state for the counters; node index wraps to 0 after the last input.
  always_comb begin
    node_d = node_q;
    out_d  = out_q;
    wegt_d = wegt_q;
    if (clr_i) begin
      node_d = '0;
      out_d  = '0;
      wegt_d = '0;
    end else begin
      if (fetch_i) begin
        wegt_d = wegt_q + WADDR_WIDTH'(1);
        node_d = last_node_o ? '0 : node_q + CNT_WIDTH'(1);
      end else begin
        wegt_d = wegt_q;
        node_d = node_q;
      end
      if (adv_i) begin
        out_d = out_q + CNT_WIDTH'(1);
      end else begin
        out_d = out_q;
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      node_q <= '0;
      out_q  <= '0;
      wegt_q <= '0;
    end else begin
      node_q <= node_d;
      out_q  <= out_d;
      wegt_q <= wegt_d;
    end
  end

  assign node_idx_o  = node_q;
  assign out_idx_o   = out_q;
  assign wegt_addr_o = wegt_q;

endmodule

// File: rtl/fc_operand_feeder.sv
// FC layer operand feeder: sequences node/weight/bias RAM reads into the accumulator core.
// Optional FC_FEEDER_PERF_CNT_EN adds o_cycle_cnt (cycles from i_start to o_done).
module fc_operand_feeder
  import fc_pkg::*;
#(
  parameter int IN_DATA_WITDH = 16,
  parameter int CNT_WIDTH     = 10,
  parameter int WADDR_WIDTH   = 20
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_start,
  input  logic [CNT_WIDTH-1:0]     i_num_node,
  input  logic [CNT_WIDTH-1:0]     i_num_out,
  input  logic                     i_hold,
  output logic [CNT_WIDTH-1:0]     o_node_addr,
  output logic                     o_node_ce,
  input  logic [IN_DATA_WITDH-1:0] i_node_q,
  output logic [WADDR_WIDTH-1:0]   o_wegt_addr,
  output logic                     o_wegt_ce,
  input  logic [IN_DATA_WITDH-1:0] i_wegt_q,
  output logic [CNT_WIDTH-1:0]     o_bias_addr,
  output logic                     o_bias_ce,
  input  logic [IN_DATA_WITDH-1:0] i_bias_q,
  output logic                     o_run,
  output logic                     o_valid,
  output logic [IN_DATA_WITDH-1:0] o_node,
  output logic [IN_DATA_WITDH-1:0] o_wegt,
  output logic [IN_DATA_WITDH-1:0] o_bias,
  output logic                     o_acc_done,
  output logic [CNT_WIDTH-1:0]     o_out_idx,
`ifdef FC_FEEDER_PERF_CNT_EN
  output logic [31:0]              o_cycle_cnt,
`endif
  output logic                     o_idle,
  output logic                     o_done
);

  localparam int RD_LAT = int'(RAM_RD_LATENCY);

  fc_state_e            state_q;
  logic [CNT_WIDTH-1:0] n_q, m_q;
  logic                 run_q, acc_done_q, done_q, idle_q;
  logic [RD_LAT-1:0]    valid_pipe_q, bias_pipe_q;

  logic                   start_s, fetch_s, bias_ce_s, adv_s, last_out_s, last_node_s;
  logic [CNT_WIDTH-1:0]   node_idx_s, out_idx_s;
  logic [WADDR_WIDTH-1:0] wegt_addr_s;

  assign start_s    = (state_q == ST_IDLE) && i_start;
  assign fetch_s    = (state_q == ST_FETCH) && !i_hold;
  assign bias_ce_s  = fetch_s && (node_idx_s == '0);
  assign last_out_s = (out_idx_s == (m_q - CNT_WIDTH'(1)));
  assign adv_s      = (state_q == ST_NEXT) && !last_out_s;

  fc_addr_gen #(
    .CNT_WIDTH   (CNT_WIDTH),
    .WADDR_WIDTH (WADDR_WIDTH)
  ) u_addr_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .clr_i       (start_s),
    .fetch_i     (fetch_s),
    .adv_i       (adv_s),
    .num_node_i  (n_q),
    .node_idx_o  (node_idx_s),
    .out_idx_o   (out_idx_s),
    .wegt_addr_o (wegt_addr_s),
    .last_node_o (last_node_s)
  );

  // Pass sequencer; strobes are registered on the edge entering their state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      m_q        <= '0;
      run_q      <= 1'b0;
      acc_done_q <= 1'b0;
      done_q     <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      run_q      <= 1'b0;
      acc_done_q <= 1'b0;
      done_q     <= 1'b0;
      idle_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            n_q <= i_num_node;
            m_q <= i_num_out;
            if ((i_num_node == '0) || (i_num_out == '0)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              run_q   <= 1'b1;
            end
          end else begin
            idle_q <= 1'b1;
          end
        end
        ST_RUN: state_q <= ST_FETCH;
        ST_FETCH: begin
          if (fetch_s && last_node_s) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state_q    <= ST_NEXT;
          acc_done_q <= 1'b1;
        end
        ST_NEXT: begin
          if (last_out_s) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_RUN;
            run_q   <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          idle_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

  // Align valid and the bias-select flag with the RAM read latency.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_pipe_q <= '0;
      bias_pipe_q  <= '0;
    end else begin
      valid_pipe_q <= RD_LAT'({valid_pipe_q, fetch_s});
      bias_pipe_q  <= RD_LAT'({bias_pipe_q, bias_ce_s});
    end
  end

`ifdef FC_FEEDER_PERF_CNT_EN
  logic [31:0] cyc_cnt_q;

  // Inclusive count from the start cycle; loading 2 covers the start cycle and RUN.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cyc_cnt_q <= 32'd0;
    end else if (start_s) begin
      cyc_cnt_q <= 32'd2;
    end else if ((state_q != ST_IDLE) && (state_q != ST_DONE) && (cyc_cnt_q != 32'hFFFF_FFFF)) begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
    end
  end

  assign o_cycle_cnt = cyc_cnt_q;
`endif

  assign o_node_ce   = fetch_s;
  assign o_wegt_ce   = fetch_s;
  assign o_bias_ce   = bias_ce_s;
  assign o_node_addr = node_idx_s;
  assign o_wegt_addr = wegt_addr_s;
  assign o_bias_addr = out_idx_s;
  assign o_out_idx   = out_idx_s;

  assign o_run      = run_q;
  assign o_valid    = valid_pipe_q[RD_LAT-1];
  assign o_node     = o_valid ? i_node_q : '0;
  assign o_wegt     = o_valid ? i_wegt_q : '0;
  assign o_bias     = bias_pipe_q[RD_LAT-1] ? i_bias_q : '0;
  assign o_acc_done = acc_done_q;
  assign o_done     = done_q;
  assign o_idle     = idle_q;

endmodule

// File: tb/tb_fc_operand_feeder.sv
// Scoreboard bench for fc_operand_feeder: a cycle-level event model is queued at
// start and a negedge monitor pops/compares every DUT event against it.
module tb_fc_operand_feeder;

  localparam int DW = 16;
  localparam int CW = 10;
  localparam int AW = 20;
  localparam int HMAX = 16384;

  logic          clk = 1'b0;
  logic          reset_n, i_start, i_hold;
  logic [CW-1:0] i_num_node, i_num_out;
  logic [CW-1:0] o_node_addr, o_bias_addr, o_out_idx;
  logic [AW-1:0] o_wegt_addr;
  logic          o_node_ce, o_wegt_ce, o_bias_ce, o_run, o_valid, o_acc_done, o_idle, o_done;
  logic [DW-1:0] i_node_q, i_wegt_q, i_bias_q, o_node, o_wegt, o_bias;
`ifdef FC_FEEDER_PERF_CNT_EN
  logic [31:0]   o_cycle_cnt;
  logic [31:0]   last_cnt;
`endif

  always #5 clk = ~clk;

  fc_operand_feeder #(.IN_DATA_WITDH(DW), .CNT_WIDTH(CW), .WADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_num_node(i_num_node),
    .i_num_out(i_num_out), .i_hold(i_hold),
    .o_node_addr(o_node_addr), .o_node_ce(o_node_ce), .i_node_q(i_node_q),
    .o_wegt_addr(o_wegt_addr), .o_wegt_ce(o_wegt_ce), .i_wegt_q(i_wegt_q),
    .o_bias_addr(o_bias_addr), .o_bias_ce(o_bias_ce), .i_bias_q(i_bias_q),
    .o_run(o_run), .o_valid(o_valid), .o_node(o_node), .o_wegt(o_wegt), .o_bias(o_bias),
    .o_acc_done(o_acc_done), .o_out_idx(o_out_idx),
`ifdef FC_FEEDER_PERF_CNT_EN
    .o_cycle_cnt(o_cycle_cnt),
`endif
    .o_idle(o_idle), .o_done(o_done)
  );

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;
  int t0_g = 0;
  bit done_seen = 1'b0;
  bit hold_pat [0:HMAX-1];

  always @(posedge clk) cyc <= cyc + 1;

  // RAM models: 1-cycle read latency, output holds when not enabled.
  logic [DW-1:0] node_mem [0:1023];
  logic [DW-1:0] wegt_mem [0:4095];
  logic [DW-1:0] bias_mem [0:1023];
  always @(posedge clk) begin
    if (o_node_ce) i_node_q <= node_mem[o_node_addr];
    if (o_wegt_ce) i_wegt_q <= wegt_mem[o_wegt_addr[11:0]];
    if (o_bias_ce) i_bias_q <= bias_mem[o_bias_addr];
  end

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } ev_t;

  ev_t q_run[$], q_fetch[$], q_valid[$], q_acc[$], q_done[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic ev_t mk(input int c, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] cc, input logic [31:0] d);
    ev_t e;
    e.cyc = c; e.a = a; e.b = b; e.c = cc; e.d = d;
    return e;
  endfunction

  // Reference timeline: RUN, then one fetch per unheld cycle, DRAIN, NEXT, ... DONE.
  task automatic build_expect(input int t0, input int n, input int m, input int abort_cyc);
    int r;
    int c;
    if (n == 0 || m == 0) begin
      if (t0 + 1 <= abort_cyc) q_done.push_back(mk(t0 + 1, 0, 0, 0, 0));
    end else begin
      r = t0 + 1;
      for (int j = 0; j < m; j++) begin
        if (r <= abort_cyc) q_run.push_back(mk(r, 0, 0, 0, 0));
        c = r + 1;
        for (int i = 0; i < n; i++) begin
          while (hold_pat[c]) c++;
          if (c <= abort_cyc)
            q_fetch.push_back(mk(c, i, j * n + i, (i == 0) ? 1 : 0, j));
          if (c + 1 <= abort_cyc)
            q_valid.push_back(mk(c + 1, 32'(node_mem[i]), 32'(wegt_mem[j * n + i]),
                                 (i == 0) ? 32'(bias_mem[j]) : 32'd0, 0));
          c++;
        end
        if (c + 1 <= abort_cyc) q_acc.push_back(mk(c + 1, j, 0, 0, 0));
        r = c + 2;
      end
      if (r <= abort_cyc) q_done.push_back(mk(r, 0, 0, 0, 0));
    end
  endtask

  // Monitor: every DUT event must match the head of its expectation queue.
  always @(negedge clk) begin
    ev_t e;
    if (o_run) begin
      check("run_expected", q_run.size() != 0, 1);
      check("run_valid_overlap", o_valid, 0);
      if (q_run.size() != 0) begin
        e = q_run.pop_front();
        check("run_cycle", cyc, e.cyc);
      end
    end
    if (o_node_ce) begin
      check("fetch_expected", q_fetch.size() != 0, 1);
      if (q_fetch.size() != 0) begin
        e = q_fetch.pop_front();
        check("fetch_cycle", cyc, e.cyc);
        check("node_addr", o_node_addr, e.a);
        check("wegt_addr", o_wegt_addr, e.b);
        check("wegt_ce", o_wegt_ce, 1);
        check("bias_ce", o_bias_ce, e.c);
        if (e.c[0]) check("bias_addr", o_bias_addr, e.d);
      end
    end else begin
      check("stray_ce", {o_wegt_ce, o_bias_ce}, 0);
    end
    if (o_valid) begin
      check("valid_expected", q_valid.size() != 0, 1);
      if (q_valid.size() != 0) begin
        e = q_valid.pop_front();
        check("valid_cycle", cyc, e.cyc);
        check("o_node", o_node, e.a);
        check("o_wegt", o_wegt, e.b);
        check("o_bias", o_bias, e.c);
      end
    end else begin
      check("bias_without_valid", o_bias, 0);
    end
    if (o_acc_done) begin
      check("acc_done_expected", q_acc.size() != 0, 1);
      if (q_acc.size() != 0) begin
        e = q_acc.pop_front();
        check("acc_done_cycle", cyc, e.cyc);
        check("out_idx", o_out_idx, e.a);
      end
    end
    if (o_done) begin
      done_seen = 1'b1;
      check("done_expected", q_done.size() != 0, 1);
      check("idle_during_done", o_idle, 0);
      if (q_done.size() != 0) begin
        e = q_done.pop_front();
        check("done_cycle", cyc, e.cyc);
`ifdef FC_FEEDER_PERF_CNT_EN
        check("cycle_cnt_at_done", o_cycle_cnt, e.cyc - t0_g + 1);
        last_cnt = o_cycle_cnt;
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    i_hold = (cyc < HMAX) ? hold_pat[cyc] : 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    check({tag, "_idle"}, o_idle, 1);
    check({tag, "_ctl"}, {o_run, o_valid, o_node_ce, o_wegt_ce, o_bias_ce, o_acc_done, o_done}, 0);
    check({tag, "_addr"}, {o_node_addr, o_bias_addr, o_out_idx}, 0);
    check({tag, "_waddr"}, o_wegt_addr, 0);
    check({tag, "_data"}, {o_node, o_wegt, o_bias}, 0);
  endtask

  // One layer pass: optional random/directed hold, start poke in FETCH, reset abort.
  task automatic run_pass(input int n, input int m, input int hold_pct, input int h_lo,
                          input int h_hi, input bit poke, input int abort_rel);
    int t0;
    int abort_cyc;
    bit aborted;
    t0 = cyc + 1;
    aborted = 1'b0;
    for (int k = 0; k < 600; k++)
      if (t0 + k < HMAX) hold_pat[t0 + k] = ($urandom_range(99) < hold_pct);
    if (h_lo >= 0)
      for (int k = h_lo; k <= h_hi; k++) hold_pat[t0 + k] = 1'b1;
    abort_cyc = (abort_rel >= 0) ? t0 + abort_rel : 32'h7fff_ffff;
    build_expect(t0, n, m, abort_cyc);
    done_seen = 1'b0;
    t0_g = t0;
    tick();
    i_start = 1'b1; i_num_node = CW'(n); i_num_out = CW'(m);
    tick();
    i_start = 1'b0; i_num_node = CW'($urandom); i_num_out = CW'($urandom);
    for (int k = 0; k < 600 && !done_seen; k++) begin
      i_start = (poke && cyc == t0 + 3) ? 1'b1 : 1'b0;
      if (abort_rel >= 0 && cyc == abort_cyc + 1) begin
        chk_quiet("after_abort");
        reset_n = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (abort_rel >= 0 && cyc == abort_cyc) reset_n = 1'b0;
      tick();
    end
    i_start = 1'b0;
    check("done_seen", done_seen, aborted ? 0 : 1);
    tick();
    tick();
    check("idle_after_pass", o_idle, 1);
    check("leftover_events", q_run.size() + q_fetch.size() + q_valid.size() + q_acc.size()
          + q_done.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;
    reset_n = 1'b0; i_start = 1'b0; i_hold = 1'b0;
    i_num_node = '0; i_num_out = '0;
    for (int k = 0; k < HMAX; k++) hold_pat[k] = 1'b0;
    for (int k = 0; k < 1024; k++) begin
      node_mem[k] = DW'($urandom);
      bias_mem[k] = DW'($urandom);
    end
    for (int k = 0; k < 4096; k++) wegt_mem[k] = DW'($urandom);
    repeat (3) tick();
    chk_quiet("reset");
    reset_n = 1'b1;
    tick();

    for (int k = 0; k < 4; k++) begin
      node_mem[k] = DW'(k + 1);
      wegt_mem[k] = DW'(1);
    end
    bias_mem[0] = DW'(5);
    run_pass(4, 1, 0, -1, -1, 1'b0, -1);
    run_pass(3, 2, 0, -1, -1, 1'b0, -1);
    run_pass(4, 1, 0, 3, 4, 1'b0, -1);
    run_pass(0, 3, 0, -1, -1, 1'b0, -1);
    run_pass(5, 0, 0, -1, -1, 1'b0, -1);
    run_pass(4, 2, 0, -1, -1, 1'b1, -1);
`ifdef FC_FEEDER_PERF_CNT_EN
    check("cycle_cnt_n4_m2", last_cnt, 16);
    check("cycle_cnt_held", o_cycle_cnt, 16);
`endif
    run_pass(8, 1, 0, -1, -1, 1'b0, 4);
    run_pass(3, 2, 0, -1, -1, 1'b0, -1);

    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(8, 1);
      m = $urandom_range(4, 1);
      run_pass(n, m, 25, -1, -1, (n >= 2) ? 1'b1 : 1'b0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
